nco_wave_gen: RTL

//  Parametrised numerically-controlled oscillator replacing the fixed 30-entry sine ROM stepper.

---
 rtl/nco_pkg.sv | 38 +++
 rtl/nco_wave_gen_quarter_sine_rom.sv | 31 +++
 rtl/nco_wave_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared encodings and sine table builder for the NCO
package nco_pkg;

    typedef enum logic [1:0] {
        WAVE_SINE = 2'd0,
        WAVE_TRI  = 2'd1,
        WAVE_SAW  = 2'd2,
        WAVE_SQR  = 2'd3
    } wave_e;

    // pi/2 in Q30 fixed point
    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    // Quarter-wave entry: round((2**mag_w-1) * sin(pi/2 * (idx+0.5) / 2**addr_w)).
    // Integer Taylor series keeps this usable at elaboration without real arithmetic.
    function automatic int sine_entry(input int idx, input int addr_w, input int mag_w);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint full;
        x    = (HALF_PI_Q30 * longint'(2 * idx + 1)) >>> (addr_w + 1);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 8; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        full = (longint'(1) <<< mag_w) - 1;
        return int'((full * sum + (longint'(1) <<< 29)) >>> 30);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nco_wave_gen_quarter_sine_rom.sv
// rtl/nco_wave_gen_quarter_sine_rom.sv - registered quarter-wave sine magnitude table
module quarter_sine_rom
    import nco_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int MAG_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    output logic [MAG_W-1:0]  mag
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [MAG_W-1:0] table_w [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        localparam int ENTRY = sine_entry(g, ADDR_W, MAG_W);
        assign table_w[g] = MAG_W'(ENTRY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag <= '0;
        end else begin
            mag <= table_w[addr];
        end
    end

endmodule

// File: rtl/nco_wave_gen.sv
// rtl/nco_wave_gen.sv - three-stage NCO: phase accumulator, waveform shaping, amplitude scaling
module nco_wave_gen
    import nco_pkg::*;
#(
    parameter int OUT_W      = 8,
    parameter int PHASE_W    = 16,
    parameter int LUT_ADDR_W = 6,
    parameter int AMP_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               sync,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic [PHASE_W-1:0] phase_ofs,
    input  logic [1:0]         wave_sel,
    input  logic [AMP_W-1:0]   amp,
    output logic [OUT_W-1:0]   data_out,
    output logic               data_valid,
    output logic               last
);

    // Only the phase bits that the shapers look at are carried into stage 1
    localparam int P_KEEP = max_int(OUT_W, LUT_ADDR_W + 2);
    localparam int MAG_W  = OUT_W - 1;
    localparam int PROD_W = OUT_W + AMP_W + 1;
    localparam logic [OUT_W-1:0] POS_FS = OUT_W'((1 << (OUT_W - 1)) - 1);
    localparam logic [OUT_W-1:0] NEG_FS = -POS_FS;

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] acc_sum;
    logic               acc_carry;

    assign {acc_carry, acc_sum} = {1'b0, acc} + {1'b0, phase_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (sync) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_sum;
        end
    end

    // Stage 1: phase, waveform and tags captured together so mid-run changes never mix
    logic [P_KEEP-1:0] p1;
    wave_e             ws1;
    logic              v1;
    logic              c1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1  <= '0;
            ws1 <= WAVE_SINE;
            v1  <= 1'b0;
            c1  <= 1'b0;
        end else begin
            p1  <= P_KEEP'((acc + phase_ofs) >> (PHASE_W - P_KEEP));
            ws1 <= wave_e'(wave_sel);
            v1  <= en & ~sync;
            c1  <= acc_carry & ~sync;
        end
    end

    // Stage 2: shape the non-sine waves and address the quarter-wave table
    logic [OUT_W-1:0]      pt;
    logic [1:0]            quad;
    logic [LUT_ADDR_W-1:0] idx;
    logic [LUT_ADDR_W-1:0] rom_addr;
    logic [OUT_W-1:0]      tri_u;
    logic [OUT_W-1:0]      tri_fold;
    logic [OUT_W-1:0]      raw_nxt;

    assign pt       = p1[P_KEEP-1 -: OUT_W];
    assign quad     = p1[P_KEEP-1 -: 2];
    assign idx      = p1[P_KEEP-3 -: LUT_ADDR_W];
    assign rom_addr = quad[0] ? ~idx : idx;
    assign tri_u    = {pt[OUT_W-2:0], 1'b0};
    assign tri_fold = pt[OUT_W-1] ? ~tri_u : tri_u;

    always_comb begin
        raw_nxt = {~pt[OUT_W-1], pt[OUT_W-2:0]};
        case (ws1)
            WAVE_TRI: raw_nxt = {~tri_fold[OUT_W-1], tri_fold[OUT_W-2:0]};
            WAVE_SQR: raw_nxt = pt[OUT_W-1] ? NEG_FS : POS_FS;
            default:  raw_nxt = {~pt[OUT_W-1], pt[OUT_W-2:0]};
        endcase
    end

    logic [MAG_W-1:0] mag2;

    quarter_sine_rom #(
        .ADDR_W(LUT_ADDR_W),
        .MAG_W (MAG_W)
    ) u_rom (
        .clk  (clk),
        .rst_n(rst_n),
        .addr (rom_addr),
        .mag  (mag2)
    );

    logic [OUT_W-1:0] raw2;
    logic             neg2;
    wave_e            ws2;
    logic             v2;
    logic             c2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw2 <= '0;
            neg2 <= 1'b0;
            ws2  <= WAVE_SINE;
            v2   <= 1'b0;
            c2   <= 1'b0;
        end else begin
            raw2 <= raw_nxt;
            neg2 <= quad[1];
            ws2  <= ws1;
            v2   <= v1;
            c2   <= c1;
        end
    end

    // Stage 3: sine sign restore, amplitude scaling (floor), output register
    logic [OUT_W-1:0]         mag_ext;
    logic [OUT_W-1:0]         sine_raw;
    logic [OUT_W-1:0]         raw3;
    logic signed [PROD_W-1:0] raw_wide;
    logic signed [PROD_W-1:0] amp_wide;
    logic signed [PROD_W-1:0] prod;
    logic [OUT_W-1:0]         scaled;
    logic [OUT_W-1:0]         sample;

    assign mag_ext  = {1'b0, mag2};
    assign sine_raw = neg2 ? -mag_ext : mag_ext;
    assign raw3     = (ws2 == WAVE_SINE) ? sine_raw : raw2;
    assign raw_wide = $signed({{(AMP_W + 1){raw3[OUT_W-1]}}, raw3});
    assign amp_wide = $signed({{(OUT_W + 1){1'b0}}, amp});
    assign prod     = raw_wide * amp_wide;
    assign scaled   = OUT_W'(prod >>> AMP_W);
    assign sample   = (&amp) ? raw3 : scaled;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            last       <= 1'b0;
        end else begin
            data_valid <= v2;
            last       <= v2 & c2;
            if (v2) begin
                data_out <= sample;
            end
        end
    end

endmodule
